// File: rtl/tl45_pkg.sv
// Shared constants and types for the tl45 register-read (operand fetch/issue) stage.
package tl45_pkg;

  localparam int NUM_REGS = 15;
  localparam int OPC_W    = 5;

  typedef logic [3:0] reg_idx_t;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    reg_idx_t         dr;
    reg_idx_t         sr1;
    reg_idx_t         sr2;
    logic             writes_dr;
    logic [31:0]      imm;
    logic [31:0]      pc;
  } decoded_t;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    reg_idx_t         dr;
    logic [31:0]      sr1_val;
    logic [31:0]      sr2_val;
    logic [31:0]      imm;
    logic [31:0]      pc;
  } issued_t;

  // Scoreboard lookup; a zero bit is prepended so r0 can never read as busy.
  function automatic logic reg_is_busy(input logic [NUM_REGS-1:0] busy, input reg_idx_t idx);
    logic [NUM_REGS:0] ext;
    ext = {busy, 1'b0};
    return ext[idx];
  endfunction

endpackage

// File: rtl/tl45_register_read_if.sv
// Decode-side and execute-side handshakes of the register-read stage.
interface tl45_register_read_if import tl45_pkg::*; ();

  logic                 i_valid;
  logic                 o_ready;
  logic [OPC_W-1:0]     i_opcode;
  reg_idx_t             i_dr;
  reg_idx_t             i_sr1;
  reg_idx_t             i_sr2;
  logic                 i_writes_dr;
  logic [31:0]          i_imm;
  logic [31:0]          i_pc;

  logic                 o_valid;
  logic                 i_ready;
  logic [OPC_W-1:0]     o_opcode;
  reg_idx_t             o_dr;
  logic [31:0]          o_sr1_val;
  logic [31:0]          o_sr2_val;
  logic [31:0]          o_imm;
  logic [31:0]          o_pc;

  // slave: the stage itself; master: whoever drives decode and consumes issue.
  modport slave (
    input  i_valid, i_opcode, i_dr, i_sr1, i_sr2, i_writes_dr, i_imm, i_pc, i_ready,
    output o_ready, o_valid, o_opcode, o_dr, o_sr1_val, o_sr2_val, o_imm, o_pc
  );

  modport master (
    output i_valid, i_opcode, i_dr, i_sr1, i_sr2, i_writes_dr, i_imm, i_pc, i_ready,
    input  o_ready, o_valid, o_opcode, o_dr, o_sr1_val, o_sr2_val, o_imm, o_pc
  );

endinterface

// File: rtl/tl45_hazard_check.sv
// Combinational RAW/WAW check of one instruction against the busy scoreboard.
module tl45_hazard_check import tl45_pkg::*; (
  input  logic [NUM_REGS-1:0] busy,
  input  reg_idx_t            sr1,
  input  reg_idx_t            sr2,
  input  reg_idx_t            dr,
  input  logic                writes_dr,
  output logic                hazard
);

  logic raw;
  logic waw;

  always_comb begin
    raw    = reg_is_busy(busy, sr1) | reg_is_busy(busy, sr2);
    waw    = writes_dr & reg_is_busy(busy, dr);
    hazard = raw | waw;
  end

endmodule

// File: rtl/tl45_register_read.sv
// Register-read stage: holds one decoded instruction (S0), fetches operands and issues into the output register (S1).
module tl45_register_read import tl45_pkg::*; (
  input  logic                 clk,
  input  logic                 reset,
  tl45_register_read_if.slave  bus,
  input  logic                 i_flush,
  output reg_idx_t             o_rf_addr1,
  output reg_idx_t             o_rf_addr2,
  input  logic [31:0]          i_rf_data1,
  input  logic [31:0]          i_rf_data2,
  input  logic [NUM_REGS-1:0]  i_reg_busy,
  output reg_idx_t             o_set_busy
);

  decoded_t s0_q, s0_d;
  logic     s0_valid_q, s0_valid_d;
  issued_t  s1_q, s1_d;
  logic     s1_valid_q, s1_valid_d;

  logic     hazard;
  logic     issue;
  logic     accept;
  logic     ready;

  tl45_hazard_check u_hazard (
    .busy      (i_reg_busy),
    .sr1       (s0_q.sr1),
    .sr2       (s0_q.sr2),
    .dr        (s0_q.dr),
    .writes_dr (s0_q.writes_dr),
    .hazard    (hazard)
  );

  always_comb begin
    issue  = s0_valid_q && !hazard && !i_flush && (!s1_valid_q || bus.i_ready);
    ready  = !i_flush && (!s0_valid_q || issue);
    accept = bus.i_valid && ready;

    o_rf_addr1 = s0_valid_q ? s0_q.sr1 : '0;
    o_rf_addr2 = s0_valid_q ? s0_q.sr2 : '0;
    // dr==0 already yields 0, so writes_dr alone gates the reservation.
    o_set_busy = (issue && s0_q.writes_dr) ? s0_q.dr : '0;

    s0_d       = s0_q;
    s0_valid_d = s0_valid_q;
    if (i_flush) begin
      s0_valid_d = 1'b0;
    end else if (accept) begin
      s0_valid_d     = 1'b1;
      s0_d.opcode    = bus.i_opcode;
      s0_d.dr        = bus.i_dr;
      s0_d.sr1       = bus.i_sr1;
      s0_d.sr2       = bus.i_sr2;
      s0_d.writes_dr = bus.i_writes_dr;
      s0_d.imm       = bus.i_imm;
      s0_d.pc        = bus.i_pc;
    end else if (issue) begin
      s0_valid_d = 1'b0;
    end

    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (issue) begin
      s1_valid_d   = 1'b1;
      s1_d.opcode  = s0_q.opcode;
      s1_d.dr      = s0_q.dr;
      s1_d.sr1_val = (s0_q.sr1 == '0) ? '0 : i_rf_data1;
      s1_d.sr2_val = (s0_q.sr2 == '0) ? '0 : i_rf_data2;
      s1_d.imm     = s0_q.imm;
      s1_d.pc      = s0_q.pc;
    end else if (s1_valid_q && bus.i_ready) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q       <= '0;
      s0_valid_q <= 1'b0;
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s0_q       <= s0_d;
      s0_valid_q <= s0_valid_d;
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  always_comb begin
    bus.o_ready   = ready;
    bus.o_valid   = s1_valid_q;
    bus.o_opcode  = s1_q.opcode;
    bus.o_dr      = s1_q.dr;
    bus.o_sr1_val = s1_q.sr1_val;
    bus.o_sr2_val = s1_q.sr2_val;
    bus.o_imm     = s1_q.imm;
    bus.o_pc      = s1_q.pc;
  end

endmodule

// File: tb/tb_tl45_register_read.sv
// Randomized bench for tl45_register_read against a transaction-level model with its own scoreboard and register file.
module tb_tl45_register_read;
  import tl45_pkg::*;

  localparam int NCYC    = 3000;
  localparam int RST_CYC = 1500;

  logic clk = 1'b0;
  logic reset;
  logic i_flush;
  reg_idx_t o_rf_addr1, o_rf_addr2, o_set_busy;
  logic [31:0] i_rf_data1, i_rf_data2;
  logic [NUM_REGS-1:0] i_reg_busy;

  tl45_register_read_if bus ();

  tl45_register_read dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .i_flush    (i_flush),
    .o_rf_addr1 (o_rf_addr1),
    .o_rf_addr2 (o_rf_addr2),
    .i_rf_data1 (i_rf_data1),
    .i_rf_data2 (i_rf_data2),
    .i_reg_busy (i_reg_busy),
    .o_set_busy (o_set_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OPC_W-1:0] opc;
    logic [3:0]       dr, sr1, sr2;
    logic             wr;
    logic [31:0]      imm, pc;
  } ins_t;

  typedef struct {
    logic [OPC_W-1:0] opc;
    logic [3:0]       dr;
    logic [31:0]      v1, v2, imm, pc;
  } out_t;

  // Model of the world around the stage: register file, busy bits with a writeback countdown.
  logic [31:0] rf_mem [16];
  logic [15:0] busy;
  int          cnt [16];

  // Model of the stage: accepted-but-not-issued instructions and the presented result.
  ins_t pend_q[$];
  out_t model_out;
  logic model_ovalid;

  int n_vec = 0;
  int n_err = 0;

  assign i_reg_busy = busy[15:1];
  assign i_rf_data1 = (o_rf_addr1 == 4'd0) ? 32'hDEAD_0001 : rf_mem[o_rf_addr1];
  assign i_rf_data2 = (o_rf_addr2 == 4'd0) ? 32'hDEAD_0002 : rf_mem[o_rf_addr2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_busy(input logic [3:0] r);
    return (r != 4'd0) && busy[r];
  endfunction

  ins_t pre_in;
  out_t pre_out;
  logic pre_issue, pre_accept, pre_flush, pre_iready, pre_reset;
  logic [3:0] pre_setb;

  initial begin
    ins_t p;
    logic pend, hz, exp_issue, exp_ready;
    logic [3:0] exp_setb;

    reset = 1'b1;
    i_flush = 1'b0;
    bus.i_valid = 1'b0; bus.i_opcode = '0; bus.i_dr = '0; bus.i_sr1 = '0; bus.i_sr2 = '0;
    bus.i_writes_dr = 1'b0; bus.i_imm = '0; bus.i_pc = '0; bus.i_ready = 1'b0;
    busy = '0;
    for (int r = 0; r < 16; r++) begin
      rf_mem[r] = $urandom;
      cnt[r] = 0;
    end
    rf_mem[1] = 32'd5;
    rf_mem[2] = 32'd7;
    model_ovalid = 1'b0;
    model_out = '{default: '0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_valid", bus.o_valid, 1'b0);
    chk("rst_set_busy", o_set_busy, 4'd0);
    chk("rst_o_ready", bus.o_ready, 1'b1);
    chk("rst_opcode", bus.o_opcode, '0);
    chk("rst_dr", bus.o_dr, '0);
    chk("rst_sr1_val", bus.o_sr1_val, '0);
    chk("rst_sr2_val", bus.o_sr2_val, '0);
    chk("rst_imm", bus.o_imm, '0);
    chk("rst_pc", bus.o_pc, '0);
    chk("rst_rf_addr1", o_rf_addr1, 4'd0);
    reset = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      // ---- drive this cycle's inputs ----
      reset = (cyc == RST_CYC);
      if (cyc == 0) begin
        bus.i_valid = 1'b1; bus.i_opcode = 5'd1; bus.i_dr = 4'd3; bus.i_sr1 = 4'd1;
        bus.i_sr2 = 4'd2; bus.i_writes_dr = 1'b1; bus.i_imm = 32'h0; bus.i_pc = 32'h100;
        bus.i_ready = 1'b1; i_flush = 1'b0;
      end else begin
        bus.i_valid     = ($urandom_range(0, 3) != 0) && !reset;
        bus.i_opcode    = OPC_W'($urandom);
        bus.i_dr        = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 7)) : 4'($urandom);
        bus.i_sr1       = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 7)) : 4'($urandom);
        bus.i_sr2       = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 7)) : 4'($urandom);
        bus.i_writes_dr = ($urandom_range(0, 3) != 0);
        bus.i_imm       = $urandom;
        bus.i_pc        = $urandom;
        bus.i_ready     = ($urandom_range(0, 3) != 0);
        i_flush         = (cyc > 4) && !reset && ($urandom_range(0, 15) == 0);
      end
      #1;

      // ---- expectations for this cycle from the model ----
      pend = (pend_q.size() != 0);
      p = pend ? pend_q[0] : '{default: '0};
      hz = pend && (is_busy(p.sr1) || is_busy(p.sr2) || (p.wr && is_busy(p.dr)));
      exp_issue = pend && !hz && !i_flush && (!model_ovalid || bus.i_ready);
      exp_ready = !i_flush && (!pend || exp_issue);
      exp_setb  = (exp_issue && p.wr) ? p.dr : 4'd0;

      chk("o_ready", bus.o_ready, exp_ready);
      chk("o_set_busy", o_set_busy, exp_setb);
      chk("rf_addr1", o_rf_addr1, pend ? p.sr1 : 4'd0);
      chk("rf_addr2", o_rf_addr2, pend ? p.sr2 : 4'd0);

      pre_issue  = exp_issue;
      pre_accept = bus.i_valid && exp_ready;
      pre_flush  = i_flush;
      pre_iready = bus.i_ready;
      pre_reset  = reset;
      pre_setb   = exp_setb;
      pre_in     = '{opc: bus.i_opcode, dr: bus.i_dr, sr1: bus.i_sr1, sr2: bus.i_sr2,
                     wr: bus.i_writes_dr, imm: bus.i_imm, pc: bus.i_pc};
      pre_out    = '{opc: p.opc, dr: p.dr,
                     v1: (p.sr1 == 4'd0) ? 32'd0 : rf_mem[p.sr1],
                     v2: (p.sr2 == 4'd0) ? 32'd0 : rf_mem[p.sr2],
                     imm: p.imm, pc: p.pc};

      @(posedge clk);
      #1;

      // ---- advance model across the edge ----
      if (pre_reset) begin
        pend_q.delete();
        model_ovalid = 1'b0;
        busy = '0;
        for (int r = 0; r < 16; r++) cnt[r] = 0;
        reset = 1'b0;
        chk("mid_rst_o_valid", bus.o_valid, 1'b0);
        chk("mid_rst_set_busy", o_set_busy, 4'd0);
      end else begin
        if (pre_issue) begin
          model_out = pre_out;
          model_ovalid = 1'b1;
          void'(pend_q.pop_front());
        end else if (model_ovalid && pre_iready) begin
          model_ovalid = 1'b0;
        end
        if (pre_flush) pend_q.delete();
        if (pre_accept) pend_q.push_back(pre_in);

        // Writeback: the busy bit clears and the register value changes on the same edge.
        for (int r = 1; r < 16; r++) begin
          if (cnt[r] != 0) begin
            cnt[r]--;
            if (cnt[r] == 0) begin
              busy[r] = 1'b0;
              rf_mem[r] = $urandom;
            end
          end
        end
        if (pre_setb != 4'd0) begin
          busy[pre_setb] = 1'b1;
          cnt[pre_setb] = $urandom_range(1, 5);
        end

        chk("o_valid", bus.o_valid, model_ovalid);
        if (model_ovalid) begin
          chk("o_opcode", bus.o_opcode, model_out.opc);
          chk("o_dr", bus.o_dr, model_out.dr);
          chk("o_sr1_val", bus.o_sr1_val, model_out.v1);
          chk("o_sr2_val", bus.o_sr2_val, model_out.v2);
          chk("o_imm", bus.o_imm, model_out.imm);
          chk("o_pc", bus.o_pc, model_out.pc);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tl45_register_read.md
Name: tl45_register_read

Overview:
Operand-fetch/issue stage sitting between decode and execute; the consumer side of the register file and its busy scoreboard.
- Accepts decoded instructions over a valid/ready handshake.
- Stalls on RAW/WAW hazards against the scoreboard.
- Drives register-file read addresses and captures operand data.
- Reserves the destination register via the set-busy port at issue.
- Presents operands to execute over a second valid/ready handshake.

Parameters:
- NUM_REGS, 15: architectural registers r1..r15; r0 is hardwired zero and never busy.
- OPC_W, 5: opcode field width.

Ports:
- clk  in  1  single clock, posedge.
- reset  in  1  synchronous, active-high.
- i_valid  in  1  decoded instruction valid.
- o_ready  out  1  stage can accept.
- i_opcode  in  OPC_W  opcode.
- i_dr  in  4  destination register index.
- i_sr1  in  4  source 1 index.
- i_sr2  in  4  source 2 index.
- i_writes_dr  in  1  instruction writes dr.
- i_imm  in  32  immediate.
- i_pc  in  32  instruction PC.
- i_flush  in  1  kill not-yet-issued instruction.
- o_rf_addr1  out  4  register-file read address 1.
- o_rf_addr2  out  4  register-file read address 2.
- i_rf_data1  in  32  read data 1, valid within the same cycle as address.
- i_rf_data2  in  32  read data 2.
- i_reg_busy  in  NUM_REGS  scoreboard; bit k = r(k+1) busy.
- o_set_busy  out  4  register to mark busy this edge; 0 = none.
- o_valid  out  1  issued instruction valid to execute.
- i_ready  in  1  execute accepts.
- o_opcode, o_dr, o_sr1_val, o_sr2_val, o_imm, o_pc  out  OPC_W/4/32/32/32/32  issued instruction fields.

Behaviour:
- Two slots: S0 holds an accepted instruction awaiting issue; S1 is the output register (o_* fields, o_valid = S1 valid).
- Reset: S0/S1 invalid; o_valid=0, o_set_busy=0, all o_* data fields 0; o_ready=1 in the first cycle after reset.
- Hazard (combinational on S0):
  - RAW: (sr1!=0 and busy[sr1-1]) or (sr2!=0 and busy[sr2-1]).
  - WAW: (writes_dr and dr!=0 and busy[dr-1]).
  - r0 never causes a hazard.
- o_rf_addr1/2 = S0 sr1/sr2 whenever S0 valid, else 0.
- issue = S0 valid and !hazard and !i_flush and (!o_valid or i_ready).
- On issue edge:
  - S1 captures S0 fields; sr1_val/sr2_val = i_rf_data1/2, forced to 0 for index 0.
  - o_set_busy = (writes_dr and dr!=0) ? dr : 0 during the issue cycle; otherwise 0.
- If o_valid and i_ready and !issue: S1 invalidates at the edge.
- o_ready = !S0 valid or issue; accept when i_valid and o_ready. Accept and issue in the same cycle is allowed, giving 1 instruction/cycle throughput.
- Latency: accepted at edge N → earliest o_valid at edge N+1.
- Back-to-back dependency: busy bit set at the issue edge is visible next cycle; the dependent instruction stalls until its bit reads 0. No bypass; writeback data and clear arrive on the same edge.
- i_flush:
  - Invalidates S0 and blocks issue and accept in that cycle; o_ready=0 while i_flush=1.
  - S1 is unaffected: it has already reserved its destination and must retire.
- Backpressure: while o_valid and !i_ready, S1 holds all fields stable and o_set_busy stays 0.
- Reset mid-operation overrides flush and handshakes; the scoreboard is reset externally.

Decomposition:
- tl45_pkg: NUM_REGS, OPC_W, reg index typedef (4-bit), issued-instruction struct (opcode, dr, sr1_val, sr2_val, imm, pc).
- Sub-module tl45_hazard_check: combinational scoreboard lookup for sr1/sr2/dr with the r0 exclusion; unit-tested separately.

Test Plan:
- Reset then issue ADD r3←r1,r2 with busy=0, rf data 5/7 → o_valid one cycle after accept; sr1_val=5, sr2_val=7; o_set_busy=3 for exactly one cycle.
- busy[0]=1 (r1), instr sr1=1 → o_rf_addr1=1, no issue and o_ready=0 for 3 cycles; clear busy → issue next edge with current rf data.
- sr1=0, sr2=0, dr=0, busy=all 1s → issues without stall; o_set_busy=0; operand values 0.
- Back-to-back: r4←r1 then r5←r4 → second stalls while busy[3]=1 after the first issue; issues the cycle after busy[3] clears.
- i_ready=0 for 4 cycles with S1 full and S0 full → o_* stable, o_ready=0, o_set_busy=0; i_ready=1 → S1 drains and S0 issues the same edge.
- i_flush with S0 stalled on hazard → S0 dropped, never issued, o_set_busy stays 0; S1 still drains; reset asserted with both slots full → o_valid=0 next cycle.
